// File: rtl/frame_write_arbiter.sv
// Arbitrates paint writes and full-frame clear sweeps onto one shared frame
// memory port, writing only while the panel is blanked.
module frame_write_arbiter #(
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 12,
  parameter int LAST_ADDR = 2047
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] disp_addr,
  input  logic              disp_blank,
  input  logic              p_req,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic              p_bank,
  input  logic [DATA_W-1:0] p_data,
  output logic              p_ack,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_color,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr0,
  output logic              mem_wr1,
  output logic [DATA_W-1:0] mem_wdata
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PAINT_WR = 2'd1,
    CLEAR    = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(LAST_ADDR);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              bank_q, bank_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] color_q, color_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              clr_accept_s;
  logic              paint_grant_s;
  logic              clr_last_s;

  // busy_q doubles as "clear pending" while still in IDLE/PAINT_WR
  assign clr_accept_s  = clr_start && !busy_q;
  assign paint_grant_s = (state_q == IDLE) && !busy_q && !clr_start && disp_blank && p_req;
  assign clr_last_s    = (state_q == CLEAR) && disp_blank && (cnt_q == LAST_A);

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      bank_q  <= 1'b0;
      data_q  <= '0;
      color_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      bank_q  <= bank_d;
      data_q  <= data_d;
      color_q <= color_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (busy_q || clr_start) begin
          state_d = CLEAR;
        end else if (disp_blank && p_req) begin
          state_d = PAINT_WR;
        end else begin
          state_d = IDLE;
        end
      end
      PAINT_WR: state_d = IDLE;
      CLEAR: begin
        if (clr_last_s) begin
          state_d = IDLE;
        end else begin
          state_d = CLEAR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Paint capture, clear colour latch and sweep counter
  always_comb begin
    addr_d  = addr_q;
    bank_d  = bank_q;
    data_d  = data_q;
    color_d = color_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (paint_grant_s) begin
      addr_d = p_addr;
      bank_d = p_bank;
      data_d = p_data;
    end else begin
      addr_d = addr_q;
    end
    if (clr_accept_s) begin
      busy_d  = 1'b1;
      color_d = clr_color;
      cnt_d   = '0;
    end else if (clr_last_s) begin
      // Sweep ends here; the counter parks at zero rather than wrapping on
      busy_d = 1'b0;
      done_d = 1'b1;
      cnt_d  = '0;
    end else if ((state_q == CLEAR) && disp_blank) begin
      cnt_d = cnt_q + ADDR_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Memory port and handshake outputs
  always_comb begin
    mem_addr  = disp_addr;
    mem_wr0   = 1'b0;
    mem_wr1   = 1'b0;
    mem_wdata = '0;
    p_ack     = 1'b0;
    case (state_q)
      PAINT_WR: begin
        mem_addr  = addr_q;
        mem_wr0   = !bank_q;
        mem_wr1   = bank_q;
        mem_wdata = data_q;
        p_ack     = 1'b1;
      end
      CLEAR: begin
        if (disp_blank) begin
          mem_addr  = cnt_q;
          mem_wr0   = 1'b1;
          mem_wr1   = 1'b1;
          mem_wdata = color_q;
        end else begin
          mem_addr  = disp_addr;
        end
      end
      default: begin
        mem_addr = disp_addr;
      end
    endcase
  end

  assign clr_busy = busy_q;
  assign clr_done = done_q;

endmodule

// File: tb/tb_frame_write_arbiter.sv
// Directed bench for frame_write_arbiter: every memory write is checked
// against a queue of expected writes pushed when stimulus is applied.
module tb_frame_write_arbiter;

  localparam int AW = 11;
  localparam int DW = 12;
  localparam int LAST = 2047;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] disp_addr;
  logic          disp_blank;
  logic          p_req;
  logic [AW-1:0] p_addr;
  logic          p_bank;
  logic [DW-1:0] p_data;
  logic          p_ack;
  logic          clr_start;
  logic [DW-1:0] clr_color;
  logic          clr_busy;
  logic          clr_done;
  logic [AW-1:0] mem_addr;
  logic          mem_wr0;
  logic          mem_wr1;
  logic [DW-1:0] mem_wdata;

  int n_cmp = 0;
  int n_err = 0;
  int wr_seen = 0;
  logic [1+1+AW+DW-1:0] sb[$];

  frame_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LAST_ADDR(LAST)) dut (
    .clk(clk), .reset(reset), .disp_addr(disp_addr), .disp_blank(disp_blank),
    .p_req(p_req), .p_addr(p_addr), .p_bank(p_bank), .p_data(p_data), .p_ack(p_ack),
    .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy), .clr_done(clr_done),
    .mem_addr(mem_addr), .mem_wr0(mem_wr0), .mem_wr1(mem_wr1), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    disp_addr = AW'($urandom_range(0, LAST));
  endtask

  task automatic push_clear(input logic [DW-1:0] col);
    for (int a = 0; a <= LAST; a++) sb.push_back({1'b1, 1'b1, AW'(a), col});
  endtask

  // Scoreboard monitor: every strobe must match the next expected write
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_wr0 || mem_wr1) begin
        wr_seen++;
        if (sb.size() == 0) begin
          chk("unexpected_write", {7'd0, mem_wr0, mem_wr1, mem_addr, mem_wdata}, 32'd0);
        end else begin
          chk("write", {7'd0, mem_wr0, mem_wr1, mem_addr, mem_wdata}, {7'd0, sb.pop_front()});
        end
      end else begin
        chk("idle_addr", 32'(mem_addr), 32'(disp_addr));
      end
    end
  end

  initial begin
    bit seen;
    reset = 1'b1; disp_addr = 11'h2A5; disp_blank = 1'b0; p_req = 1'b0;
    p_addr = 11'h000; p_bank = 1'b0; p_data = 12'h000; clr_start = 1'b0; clr_color = 12'h000;
    nxt(); nxt();
    #2;
    chk("rst_ack", 32'(p_ack), 32'd0);
    chk("rst_busy", 32'(clr_busy), 32'd0);
    chk("rst_done", 32'(clr_done), 32'd0);
    chk("rst_wr", {30'd0, mem_wr0, mem_wr1}, 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'(disp_addr));
    nxt(); reset = 1'b0;

    // Single paint to bank1
    nxt();
    disp_blank = 1'b1; p_req = 1'b1; p_addr = 11'h123; p_bank = 1'b1; p_data = 12'h004;
    sb.push_back({1'b0, 1'b1, 11'h123, 12'h004});
    #2; chk("paint_ack_early", 32'(p_ack), 32'd0);
    nxt(); p_req = 1'b0;
    #2; chk("paint_ack", 32'(p_ack), 32'd1);
    nxt();
    #2; chk("paint_ack_once", 32'(p_ack), 32'd0);

    // Stall while panel scans, then write one cycle after blank rises
    nxt();
    disp_blank = 1'b0; p_req = 1'b1; p_addr = 11'h055; p_bank = 1'b0; p_data = 12'hABC;
    for (int i = 0; i < 10; i++) begin
      #2; chk("stall_ack", 32'(p_ack), 32'd0);
      nxt();
    end
    disp_blank = 1'b1;
    sb.push_back({1'b1, 1'b0, 11'h055, 12'hABC});
    nxt(); p_req = 1'b0;
    #2; chk("stall_release_ack", 32'(p_ack), 32'd1);
    nxt();
    #2; chk("stall_sb_empty", 32'(sb.size()), 32'd0);

    // Full clear with continuous blanking
    clr_start = 1'b1; clr_color = 12'hFFF;
    push_clear(12'hFFF);
    nxt(); clr_start = 1'b0;
    for (int i = 0; i <= LAST; i++) begin
      #2;
      if (i == 0 || i == LAST) begin
        chk("clr_busy", 32'(clr_busy), 32'd1);
        chk("clr_done_early", 32'(clr_done), 32'd0);
      end
      nxt();
    end
    #2;
    chk("clr_done", 32'(clr_done), 32'd1);
    chk("clr_busy_end", 32'(clr_busy), 32'd0);
    chk("clr_sb_empty", 32'(sb.size()), 32'd0);
    nxt();
    #2; chk("clr_done_once", 32'(clr_done), 32'd0);

    // Paint and clear requested together; clear wins, re-trigger ignored
    nxt();
    p_req = 1'b1; p_addr = 11'h321; p_bank = 1'b0; p_data = 12'h5A5;
    clr_start = 1'b1; clr_color = 12'h0F0;
    push_clear(12'h0F0);
    sb.push_back({1'b1, 1'b0, 11'h321, 12'h5A5});
    nxt(); clr_start = 1'b0;
    for (int i = 0; i <= LAST; i++) begin
      clr_start = (i == 100) ? 1'b1 : 1'b0;
      clr_color = (i == 100) ? 12'h111 : 12'h0F0;
      #2; chk("cont_no_ack", 32'(p_ack), 32'd0);
      nxt();
    end
    clr_start = 1'b0;
    #2;
    chk("cont_done", 32'(clr_done), 32'd1);
    chk("cont_ack_in_done", 32'(p_ack), 32'd0);
    nxt(); p_req = 1'b0;
    #2; chk("cont_ack", 32'(p_ack), 32'd1);
    nxt();
    #2; chk("cont_sb_empty", 32'(sb.size()), 32'd0);

    // Gapped clear: blanking toggles every cycle
    disp_blank = 1'b0; clr_start = 1'b1; clr_color = 12'h3C3;
    push_clear(12'h3C3);
    wr_seen = 0;
    nxt(); clr_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6000 && !seen; i++) begin
      disp_blank = ~disp_blank;
      #2;
      if (clr_done) seen = 1'b1;
      else nxt();
    end
    chk("gap_done_seen", 32'(seen), 32'd1);
    chk("gap_write_count", 32'(wr_seen), 32'(LAST + 1));
    chk("gap_sb_empty", 32'(sb.size()), 32'd0);
    nxt(); disp_blank = 1'b1;

    // Reset in the middle of a sweep, then restart from address 0
    clr_start = 1'b1; clr_color = 12'hABC;
    push_clear(12'hABC);
    nxt(); clr_start = 1'b0;
    for (int i = 0; i < 500; i++) nxt();
    reset = 1'b1;
    sb.delete();
    #2;
    chk("mid_rst_ack", 32'(p_ack), 32'd0);
    chk("mid_rst_busy", 32'(clr_busy), 32'd0);
    chk("mid_rst_done", 32'(clr_done), 32'd0);
    chk("mid_rst_wr", {30'd0, mem_wr0, mem_wr1}, 32'd0);
    chk("mid_rst_wdata", 32'(mem_wdata), 32'd0);
    chk("mid_rst_addr", 32'(mem_addr), 32'(disp_addr));
    nxt(); nxt(); reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #2; chk("abort_no_done", 32'(clr_done), 32'd0);
      nxt();
    end
    clr_start = 1'b1; clr_color = 12'h00F;
    push_clear(12'h00F);
    nxt(); clr_start = 1'b0;
    for (int i = 0; i <= LAST; i++) nxt();
    #2;
    chk("restart_done", 32'(clr_done), 32'd1);
    chk("restart_sb_empty", 32'(sb.size()), 32'd0);
    nxt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
